// File: rtl/fu_pkg.sv
// Shared definitions for the integer functional units: op encodings and helpers.
// No logic of its own; no latency; no backpressure.
// The add/sub unit uses these to decode issued ops.
package fu_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        SLT  = 3'd2,
        SLTU = 3'd3,
        ADDW = 3'd4,
        SUBW = 3'd5
    } addsub_op_e;

    localparam int W_BITS = 32;

    // Compares are computed as a subtraction, so they need the inverted operand too.
    function automatic logic is_sub(input addsub_op_e op);
        return (op == SUB) || (op == SLT) || (op == SLTU) || (op == SUBW);
    endfunction

endpackage

// File: rtl/carrylookaheadadder.sv
// N-bit parallel-prefix (Kogge-Stone) adder; res[N] is the carry out.
// Purely combinational, zero latency.
// No handshake; the enclosing pipeline owns any backpressure.
module carrylookaheadadder #(
    parameter int N = 65
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   res
);

    localparam int LVL = (N > 1) ? $clog2(N) : 1;

    logic [LVL:0][N-1:0] g;
    logic [LVL:0][N-1:0] p;

    always_comb begin
        g    = '0;
        p    = '0;
        res  = '0;
        g[0] = a & b;
        p[0] = a ^ b;
        for (int lv = 0; lv < LVL; lv++) begin
            for (int i = 0; i < N; i++) begin
                // j folds back onto i below the span so the index never leaves range.
                int  d;
                int  j;
                logic far;
                d   = 1 << lv;
                far = (i >= d);
                j   = far ? (i - d) : i;
                g[lv+1][i] = g[lv][i] | (far & p[lv][i] & g[lv][j]);
                p[lv+1][i] = far ? (p[lv][i] & p[lv][j]) : p[lv][i];
            end
        end
        res[0] = p[0][0];
        for (int i = 1; i < N; i++) begin
            res[i] = p[0][i] ^ g[LVL][i-1];
        end
        res[N] = g[LVL][N-1];
    end

endmodule

// File: rtl/int_addsub_stage.sv
// Two-stage integer ADD/SUB/SLT/SLTU/ADDW/SUBW unit; ADDSUB_FLAGS_EN adds the out_ovf flag.
// Latency 2 cycles issue->out_valid, 1 op/cycle when unstalled.
// out_ready low freezes the output regs; S1 then holds and in_ready drops.
module int_addsub_stage
    import fu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
`ifdef ADDSUB_FLAGS_EN
    output logic             out_ovf,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam int N = XLEN + 1;

    logic             s1_valid;
    logic             s2_valid;
    logic             s2_adv;
    addsub_op_e       s1_op;
    logic [N-1:0]     a1;
    logic [N-1:0]     b1;
    logic             s1_b_msb;
    logic [TAG_W-1:0] s1_tag;

    addsub_op_e       op_dec;
    logic             sub_dec;

    logic [N:0]               res;
    logic [XLEN-1:0]          sum;
    logic                     cout;
    logic                     slt_bit;
    logic signed [W_BITS-1:0] w_sum;
    logic [XLEN-1:0]          fmt;
    logic                     unused_res;

    // Unused encodings decode to ADD.
    assign op_dec  = (in_op > SUBW) ? ADD : addsub_op_e'(in_op);
    assign sub_dec = is_sub(op_dec);

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= ADD;
            a1       <= '0;
            b1       <= '0;
            s1_b_msb <= 1'b0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op    <= op_dec;
                a1       <= {in_a, sub_dec};
                b1       <= {in_b ^ {XLEN{sub_dec}}, sub_dec};
                s1_b_msb <= in_b[XLEN-1];
                s1_tag   <= in_tag;
            end
        end
    end

    // The doubled LSB pushes the subtract's +1 into bit 1, so no carry-in port is needed.
    carrylookaheadadder #(.N(N)) u_cla (
        .a   (a1),
        .b   (b1),
        .res (res)
    );

    assign sum        = res[XLEN:1];
    assign cout       = res[XLEN+1];
    assign unused_res = res[0];
    assign w_sum      = sum[W_BITS-1:0];
    assign slt_bit    = (a1[XLEN] ^ s1_b_msb) ? a1[XLEN] : sum[XLEN-1];

    always_comb begin
        fmt = sum;
        case (s1_op)
            ADD, SUB:   fmt = sum;
            ADDW, SUBW: fmt = XLEN'(w_sum);
            SLT:        fmt = XLEN'(slt_bit);
            SLTU:       fmt = XLEN'(!cout);
            default:    fmt = sum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= fmt;
                out_tag  <= s1_tag;
            end
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic ovf_nxt;

    // b1 already holds the effective (possibly inverted) operand.
    always_comb begin
        ovf_nxt = 1'b0;
        case (s1_op)
            ADD, SUB:   ovf_nxt = (a1[XLEN] == b1[XLEN]) && (sum[XLEN-1] != a1[XLEN]);
            ADDW, SUBW: ovf_nxt = (a1[W_BITS] == b1[W_BITS]) && (sum[W_BITS-1] != a1[W_BITS]);
            default:    ovf_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (!flush && s2_adv && s1_valid) begin
            out_ovf <= ovf_nxt;
        end
    end
`else
    // Without flags the result path above is the whole unit.
`endif

endmodule

// File: tb/tb_int_addsub_stage.sv
// Scoreboard bench for int_addsub_stage: directed ops, backpressure, flush, reset, random mix.
module tb_int_addsub_stage;

    localparam int XLEN  = 64;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef ADDSUB_FLAGS_EN
    logic             out_ovf;
`endif

    always #5 clk = ~clk;

    int_addsub_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ADDSUB_FLAGS_EN
        .out_ovf   (out_ovf),
`endif
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } exp_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               n_out    = 0;
    logic             acc      = 1'b0;
    logic [TAG_W-1:0] tag_ctr  = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [TAG_W-1:0] tag);
        exp_t        e;
        logic [63:0] s;
        logic [31:0] w;
        e.tag = tag;
        e.ovf = 1'b0;
        case (op)
            3'd1: begin
                s = a - b;
                e.data = s;
                e.ovf  = (a[63] != b[63]) && (s[63] != a[63]);
            end
            3'd2: e.data = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: e.data = (a < b) ? 64'd1 : 64'd0;
            3'd4: begin
                w = a[31:0] + b[31:0];
                e.data = {{32{w[31]}}, w};
                e.ovf  = (a[31] == b[31]) && (w[31] != a[31]);
            end
            3'd5: begin
                w = a[31:0] - b[31:0];
                e.data = {{32{w[31]}}, w};
                e.ovf  = (a[31] != b[31]) && (w[31] != a[31]);
            end
            default: begin
                s = a + b;
                e.data = s;
                e.ovf  = (a[63] == b[63]) && (s[63] != a[63]);
            end
        endcase
        return e;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(7))
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h0000_0000_7FFF_FFFF;
            4:       return 64'h8000_0000_0000_0000;
            5:       return 64'($urandom_range(15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One clock: score both handshakes as they stand before the edge, then move to the next negedge.
    task automatic cycle();
        exp_t e;
        acc = 1'b0;
        #1;
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("out_without_pending", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("data", out_data, e.data);
                chk("tag", 64'(out_tag), 64'(e.tag));
`ifdef ADDSUB_FLAGS_EN
                chk("ovf", 64'(out_ovf), 64'(e.ovf));
`endif
            end
        end
        if (flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back(model(in_op, in_a, in_b, in_tag));
            acc = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag_ctr;
        tag_ctr  = tag_ctr + 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 50 && sb.size() != 0; k++) cycle();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          base;
        logic [63:0] held;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        held = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
`ifdef ADDSUB_FLAGS_EN
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Two-cycle latency of a single ADD.
        in_valid = 1'b1; in_op = 3'd0; in_a = 64'd5; in_b = 64'd7; in_tag = 6'd1;
        cycle();
        in_valid = 1'b0;
        chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
        cycle();
        chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
        chk("add_5_7", out_data, 64'd12);
        cycle();

        // Directed values, issued back to back.
        send(3'd1, 64'd5, 64'd7);
        send(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        send(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        send(3'd3, 64'd0, 64'd0);
        send(3'd4, 64'h0000_0000_7FFF_FFFF, 64'd1);
        send(3'd5, 64'd0, 64'd1);
        send(3'd7, 64'd3, 64'd4);
        send(3'd6, 64'd10, 64'd20);
        send(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        send(3'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        send(3'd1, 64'h8000_0000_0000_0000, 64'd1);
        drain();

        // Back-to-back stream with a 3-cycle writeback stall.
        sent = 0;
        base = n_out;
        for (int c = 0; c < 60; c++) begin
            if (sent >= 8 && sb.size() == 0) break;
            out_ready = !(c >= 5 && c < 8);
            in_valid  = (sent < 8);
            in_op     = 3'(sent % 6);
            in_a      = 64'h0123_4567_89AB_CDEF * 64'(sent + 1);
            in_b      = 64'hFEDC_BA98_7654_3210 ^ (64'(sent) << 7);
            in_tag    = 6'(16 + sent);
            #1;
            if (c >= 5 && c < 8) begin
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                if (c == 5) held = out_data;
                else chk("bp_hold", out_data, held);
            end
            cycle();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(n_out - base), 64'd8);
        drain();

        // Flush with both stages full and a new op offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_a = 64'd1; in_b = 64'd2; in_tag = 6'd40;
        cycle();
        in_a = 64'd3; in_tag = 6'd41;
        cycle();
        chk("flush_pre_full", 64'(out_valid), 64'd1);
        chk("flush_pre_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_a = 64'd9; in_tag = 6'd42;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("flush_no_out", 64'(out_valid), 64'd0);
            cycle();
        end
        base = n_out;
        send(3'd0, 64'd40, 64'd2);
        drain();
        chk("post_flush_done", 64'(n_out - base), 64'd1);

        // Asynchronous reset with a result sitting at the output.
        out_ready = 1'b1;
        send(3'd0, 64'd100, 64'd1);
        send(3'd1, 64'd100, 64'd1);
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_data", out_data, 64'd0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rst_no_escape", 64'(out_valid), 64'd0);
            cycle();
        end

        // Random mix with random writeback stalls.
        acc = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(3) != 0);
                in_op    = 3'($urandom_range(7));
                in_a     = pick();
                in_b     = pick();
                in_tag   = tag_ctr;
                tag_ctr  = tag_ctr + 1'b1;
            end
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
